// File: rtl/fetch_queue.sv
// Instruction prefetch unit: issues in-order fetches over a req/gnt/rvalid port
// and buffers returned instructions in a DEPTH-entry FIFO, flushing on redirect.
module fetch_queue #(
    parameter int unsigned         DATA_W   = 32,
    parameter int unsigned         ADDR_W   = 32,
    parameter int unsigned         DEPTH    = 4,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter int unsigned         CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_in,
    output logic              imem_req_out,
    output logic [ADDR_W-1:0] imem_addr_out,
    input  logic              imem_gnt_in,
    input  logic              imem_rvalid_in,
    input  logic [DATA_W-1:0] imem_rdata_in,
    input  logic              redirect_in,
    input  logic [ADDR_W-1:0] redirect_pc_in,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] ins_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [CNT_W-1:0]  count_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [ADDR_W-1:0]  fetch_pc_q, tag_q;
    logic [DATA_W-1:0]  ins_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q  [DEPTH];

    logic space_idle, space_wait, grant, push, pop;

    assign space_idle = 32'(count_q) < DEPTH;
    // Back-to-back issue must leave room for the response landing this cycle.
    assign space_wait = (32'(count_q) + 32'd1) < DEPTH;

    always_comb begin
        imem_req_out = 1'b0;
        if (reset_in && !redirect_in) begin
            unique case (state_q)
                StIdle:  imem_req_out = space_idle;
                StWait:  imem_req_out = imem_rvalid_in && space_wait;
                default: imem_req_out = 1'b0;
            endcase
        end
    end

    assign imem_addr_out = fetch_pc_q;
    assign grant         = imem_req_out && imem_gnt_in;
    assign push          = (state_q == StWait) && imem_rvalid_in && !redirect_in;
    assign pop           = valid_out && ready_in && !redirect_in;

    assign valid_out = (count_q != '0);
    assign ins_out   = ins_mem_q[rd_ptr_q];
    assign pc_out    = pc_mem_q[rd_ptr_q];
    assign count_out = count_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant) state_d = StWait;
            end
            StWait: begin
                if (redirect_in)         state_d = imem_rvalid_in ? StIdle : StDrop;
                else if (imem_rvalid_in) state_d = grant ? StWait : StIdle;
            end
            StDrop: begin
                if (imem_rvalid_in) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (redirect_in)        count_d = '0;
        else if (push && !pop)  count_d = count_q + 1'b1;
        else if (pop && !push)  count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q    <= StIdle;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fetch_pc_q <= RESET_PC;
            tag_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ins_mem_q[i] <= '0;
                pc_mem_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (redirect_in) begin
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
                fetch_pc_q <= redirect_pc_in;
            end else begin
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                if (push) begin
                    wr_ptr_q            <= wr_ptr_q + 1'b1;
                    ins_mem_q[wr_ptr_q] <= imem_rdata_in;
                    // Stored as address+4 to match the IF/ID PC convention.
                    pc_mem_q[wr_ptr_q]  <= tag_q + ADDR_W'(4);
                end
                if (grant) begin
                    fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
                    tag_q      <= fetch_pc_q;
                end
            end
        end
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction prefetch unit. It replaces the fixed PC register, PC+4 adder and combinational instruction-memory read of the pipelined core. It issues in-order fetch requests to a variable-latency instruction memory using a req/gnt/rvalid handshake, and buffers returned instructions in a DEPTH-entry FIFO. It presents the head entry to the IF/ID register, and flushes and refetches on branch/jump redirect.

## Interface
- DATA_W, 32, instruction width
- ADDR_W, 32, address width
- DEPTH, 4, FIFO entries; power of 2, ≥2
- RESET_PC, 0, first fetch address after reset
- CNT_W, $clog2(DEPTH+1), occupancy width (derived)

- clk  in  1  clock; all state updates on rising edge
- reset_in  in  1  asynchronous, active-low reset
- imem_req_out  out  1  fetch request
- imem_addr_out  out  ADDR_W  fetch address (fetch_pc)
- imem_gnt_in  in  1  memory accepts request this cycle
- imem_rvalid_in  in  1  response valid
- imem_rdata_in  in  DATA_W  response instruction
- redirect_in  in  1  branch/jump taken; flush and refetch
- redirect_pc_in  in  ADDR_W  new fetch address
- ready_in  in  1  consumer (IF/ID write enable) accepts head
- valid_out  out  1  head entry valid (count≠0)
- ins_out  out  DATA_W  head instruction
- pc_out  out  ADDR_W  head address + 4 (IF/ID PC convention)
- count_out  out  CNT_W  FIFO occupancy

## Operation
- Storage: DEPTH entries of {addr, ins}; rd_ptr/wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count ranges from 0 to DEPTH.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; its response is kept.
  - DROP: one request outstanding; its response is discarded.
- At most one request is outstanding. Handshake completes when imem_req_out && imem_gnt_in.
- imem_req_out is asserted (combinationally) when redirect_in=0 and either:
  - IDLE and count<DEPTH, or
  - WAIT and imem_rvalid_in and count+1<DEPTH. This allows back-to-back issue.
- If the grant is not given, imem_req_out stays high with a stable address until granted. The only exception is redirect_in, which withdraws the request.
- On grant: fetch_pc ← fetch_pc+4, modulo 2^ADDR_W. The granted address is held for tagging; state → WAIT.
- WAIT with rvalid: push {tag addr, imem_rdata_in}. State → WAIT if a new grant occurs in the same cycle, else IDLE.
- DROP with rvalid: discard the data; state → IDLE. No issue in that cycle.
- rvalid in IDLE is ignored.
- Pop when valid_out && ready_in: rd_ptr++, count--.
- Push and pop in the same cycle: count is unchanged. The space rule guarantees a push never overflows.
- redirect_in has priority over push, pop and issue:
  - Clear: count←0, rd_ptr←wr_ptr←0; fetch_pc←redirect_pc_in.
  - State on redirect:
    - IDLE → IDLE.
    - WAIT without rvalid → DROP.
    - WAIT with rvalid → IDLE; the data is dropped.
    - DROP without rvalid → DROP; fetch_pc is still updated.
    - DROP with rvalid → IDLE; the data is dropped.
  - A pop in the redirect cycle has no effect beyond the clear.

## Timing
- Reset (reset_in=0) is immediate, without a clock:
  - state=IDLE, count=0, pointers=0, fetch_pc=RESET_PC.
  - valid_out=0, count_out=0, ins_out=0, pc_out=0 (storage cleared), imem_req_out=0.
  - imem_addr_out=RESET_PC.
- First rising edge after release: imem_req_out=1.
- Zero-wait memory (gnt same cycle, rvalid one cycle later):
  - First valid_out is asserted 2 cycles after the first request.
  - Sustained throughput is 1 instruction/cycle.
- Redirect to first request: the next cycle if IDLE. From DROP, the first cycle after the dropped response.
- valid_out, ins_out, pc_out and count_out are functions of registered state only.
- imem_req_out combinationally depends on imem_rvalid_in, imem_gnt_in (via state only) and redirect_in.
- Reset asserted mid-operation discards everything, including an outstanding request. The memory must be reset by the same reset_in.

## Test plan
- Reset release, RESET_PC=0, gnt=1, rvalid 1-cycle latency, ready_in=0:
  - Addresses 0x0, 0x4, 0x8, 0xC are issued on consecutive cycles.
  - valid_out first rises with ins=mem[0x0] and pc_out=0x4.
  - count_out saturates at 4; imem_req_out=0 while full.
- Full FIFO, ready_in=1 for one cycle:
  - count_out 4→3; the head advances to pc_out=0x8.
  - imem_req_out reasserts the next cycle with addr 0x10.
- redirect_in=1 with redirect_pc_in=0x100 while in WAIT, response arriving 3 cycles later:
  - count_out=0 the next cycle; the late response is discarded.
  - The next request uses addr 0x100; the first valid head has pc_out=0x104.
- redirect_in=1 to 0x200 in the same cycle as imem_rvalid_in:
  - The data is not pushed; state is IDLE.
  - imem_addr_out=0x200 with req=1 the next cycle.
- Wrap-around, RESET_PC=0xFFFFFFF8:
  - Issued addresses are 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
  - The second entry's pc_out=0x0; FIFO pointers wrap after DEPTH pushes with data order preserved.
- reset_in pulsed low for half a cycle with count_out=3 and a request outstanding:
  - All outputs reach reset values without a clock edge.
  - After release, fetching restarts at RESET_PC.
